namuru_dump_sequencer: RTL and testbench

- Controller for the GPS correlator's WISHBONE slave port, in the system clock domain, between the CPU bus and the correlator bridge.
- On each accumulation interrupt it reads every channel's accumulation registers in a fixed order and streams the words out with tags, so software or a downstream buffer need not poll.
- It arbitrates the single correlator port between this sequencer and CPU pass-through accesses.

---
 rtl/namuru_dump_sequencer_if.sv | 49 ++++
 rtl/namuru_dump_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_namuru_dump_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/namuru_dump_sequencer_if.sv
// Bus bundle for namuru_dump_sequencer.
// Groups the CPU WISHBONE slave port, the correlator WISHBONE master port and
// the tagged dump stream.
//   slave  : sequencer view. It takes the CPU request, drives the correlator
//            request and drives the dump stream.
//   master : environment view. CPU, correlator bridge and dump sink.
interface namuru_dump_sequencer_if;
  // CPU slave port
  logic [31:0] cpu_adr_i;
  logic [31:0] cpu_dat_i;
  logic [31:0] cpu_dat_o;
  logic [3:0]  cpu_sel_i;
  logic        cpu_stb_i;
  logic        cpu_cyc_i;
  logic        cpu_we_i;
  logic        cpu_ack_o;
  // correlator master port
  logic [31:0] cor_adr_o;
  logic [31:0] cor_dat_o;
  logic [31:0] cor_dat_i;
  logic [3:0]  cor_sel_o;
  logic        cor_stb_o;
  logic        cor_cyc_o;
  logic        cor_we_o;
  logic        cor_ack_i;
  // dump stream
  logic [31:0] dump_dat_o;
  logic [7:0]  dump_tag_o;
  logic        dump_valid_o;
  logic        dump_ready_i;

  modport slave (
    input  cpu_adr_i, cpu_dat_i, cpu_sel_i, cpu_stb_i, cpu_cyc_i, cpu_we_i,
    output cpu_dat_o, cpu_ack_o,
    output cor_adr_o, cor_dat_o, cor_sel_o, cor_stb_o, cor_cyc_o, cor_we_o,
    input  cor_dat_i, cor_ack_i,
    output dump_dat_o, dump_tag_o, dump_valid_o,
    input  dump_ready_i
  );

  modport master (
    output cpu_adr_i, cpu_dat_i, cpu_sel_i, cpu_stb_i, cpu_cyc_i, cpu_we_i,
    input  cpu_dat_o, cpu_ack_o,
    input  cor_adr_o, cor_dat_o, cor_sel_o, cor_stb_o, cor_cyc_o, cor_we_o,
    output cor_dat_i, cor_ack_i,
    input  dump_dat_o, dump_tag_o, dump_valid_o,
    output dump_ready_i
  );
endinterface

// File: rtl/namuru_dump_sequencer.sv
// namuru_dump_sequencer
// Owns the single correlator WISHBONE port. On each rising edge of accum_int it
// reads REGS_PER_CH registers from each of NUM_CH channels and streams every
// word out with a {channel, register} tag. When no dump is running, CPU
// accesses pass straight through to the correlator.
// Ports:
//   sys_clk, sys_rst   clock; asynchronous active-high reset
//   accum_int          accumulation interrupt (level, already in sys_clk)
//   bus                CPU slave, correlator master and dump stream signals
//   dump_done_o        one-cycle pulse when a full dump has been streamed
//   dump_err_o         sticky flag, set when a correlator access timed out
//   overrun_cnt_o      saturating count of interrupts that could not be queued
module namuru_dump_sequencer #(
  parameter int unsigned NUM_CH      = 12,
  parameter int unsigned REGS_PER_CH = 6,
  parameter int unsigned CH_SHIFT    = 5,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          accum_int,
  namuru_dump_sequencer_if.slave        bus,
  output logic                          dump_done_o,
  output logic                          dump_err_o,
  output logic [7:0]                    overrun_cnt_o
);

  typedef enum logic [2:0] {S_IDLE, S_CPU, S_SEQ_REQ, S_SEQ_OUT, S_DONE} state_t;

  localparam logic [3:0] CH_LAST  = 4'(NUM_CH - 1);
  localparam logic [3:0] REG_LAST = 4'(REGS_PER_CH - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic        r_accum_q, r_pending;
  logic [3:0]  r_ch, r_reg;
  logic [7:0]  r_tmo, w_tmo_nxt;
  logic        w_rise, w_start, w_load, w_accept, w_tmo_err, w_last, w_seq_busy;
  logic [31:0] w_seq_adr;

  assign w_rise     = accum_int & ~r_accum_q;
  assign w_last     = (r_ch == CH_LAST) && (r_reg == REG_LAST);
  assign w_seq_busy = (r_state == S_SEQ_REQ) || (r_state == S_SEQ_OUT);
  assign w_seq_adr  = BASE_ADR + ({28'd0, r_ch} << CH_SHIFT) + ({28'd0, r_reg} << 2);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_tmo_nxt        = '0;
    w_start          = 1'b0;
    w_load           = 1'b0;
    w_accept         = 1'b0;
    w_tmo_err        = 1'b0;
    bus.cor_adr_o    = '0;
    bus.cor_dat_o    = '0;
    bus.cor_sel_o    = '0;
    bus.cor_stb_o    = 1'b0;
    bus.cor_cyc_o    = 1'b0;
    bus.cor_we_o     = 1'b0;
    bus.cpu_dat_o    = '0;
    bus.cpu_ack_o    = 1'b0;
    dump_done_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // a queued dump wins over a waiting CPU request
        if (r_pending) begin
          w_start     = 1'b1;
          w_state_nxt = S_SEQ_REQ;
        end else if (bus.cpu_cyc_i && bus.cpu_stb_i) begin
          w_state_nxt = S_CPU;
        end
      end
      S_CPU: begin
        bus.cor_adr_o = bus.cpu_adr_i;
        bus.cor_dat_o = bus.cpu_dat_i;
        bus.cor_sel_o = bus.cpu_sel_i;
        bus.cor_we_o  = bus.cpu_we_i;
        bus.cor_cyc_o = bus.cpu_cyc_i;
        bus.cor_stb_o = bus.cpu_stb_i;
        bus.cpu_dat_o = bus.cor_dat_i;
        bus.cpu_ack_o = bus.cor_ack_i;
        if (!bus.cpu_cyc_i || bus.cor_ack_i) begin
          w_state_nxt = S_IDLE;
        end else if (bus.cpu_stb_i) begin
          if (r_tmo == TMO_LAST) begin
            w_tmo_err   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_tmo_nxt = r_tmo + 8'd1;
          end
        end else begin
          w_tmo_nxt = r_tmo;
        end
      end
      S_SEQ_REQ: begin
        bus.cor_cyc_o = 1'b1;
        bus.cor_stb_o = 1'b1;
        bus.cor_sel_o = 4'hF;
        bus.cor_adr_o = w_seq_adr;
        if (bus.cor_ack_i) begin
          w_load      = 1'b1;
          w_state_nxt = S_SEQ_OUT;
        end else if (r_tmo == TMO_LAST) begin
          w_tmo_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 8'd1;
        end
      end
      S_SEQ_OUT: begin
        if (bus.dump_valid_o && bus.dump_ready_i) begin
          w_accept    = 1'b1;
          w_state_nxt = w_last ? S_DONE : S_SEQ_REQ;
        end
      end
      S_DONE: begin
        dump_done_o = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // dump datapath and channel/register indices
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ch             <= '0;
      r_reg            <= '0;
      bus.dump_dat_o   <= '0;
      bus.dump_tag_o   <= '0;
      bus.dump_valid_o <= 1'b0;
      dump_err_o       <= 1'b0;
    end else begin
      if (w_start) begin
        r_ch  <= '0;
        r_reg <= '0;
      end
      if (w_load) begin
        bus.dump_dat_o   <= bus.cor_dat_i;
        bus.dump_tag_o   <= {r_ch, r_reg};
        bus.dump_valid_o <= 1'b1;
      end
      if (w_accept) begin
        bus.dump_valid_o <= 1'b0;
        if (r_reg == REG_LAST) begin
          r_reg <= '0;
          r_ch  <= r_ch + 4'd1;
        end else begin
          r_reg <= r_reg + 4'd1;
        end
      end
      if (w_tmo_err) dump_err_o <= 1'b1;
    end
  end

  // A rise that cannot be queued (dump running or one already pending, which
  // includes the cycle IDLE consumes pending) is counted as an overrun but
  // still leaves pending set, so exactly one more dump follows.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_accum_q     <= 1'b0;
      r_pending     <= 1'b0;
      overrun_cnt_o <= '0;
    end else begin
      r_accum_q <= accum_int;
      if (w_rise) begin
        if ((r_pending || w_seq_busy) && (overrun_cnt_o != 8'hFF))
          overrun_cnt_o <= overrun_cnt_o + 8'd1;
        r_pending <= 1'b1;
      end else if (w_start) begin
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_namuru_dump_sequencer.sv
module tb_namuru_dump_sequencer;
  localparam int unsigned NUM_CH   = 12;
  localparam int unsigned REGS     = 6;
  localparam int unsigned CH_SHIFT = 5;
  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam int unsigned TMO      = 16;
  localparam int          NWORDS   = int'(NUM_CH * REGS);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       accum = 1'b0;
  logic       done, err;
  logic [7:0] ovr;

  namuru_dump_sequencer_if bus();

  namuru_dump_sequencer #(
    .NUM_CH(NUM_CH), .REGS_PER_CH(REGS), .CH_SHIFT(CH_SHIFT),
    .BASE_ADR(BASE), .TIMEOUT(TMO)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .accum_int(accum), .bus(bus),
    .dump_done_o(done), .dump_err_o(err), .overrun_cnt_o(ovr)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int unsigned cycle = 0;
  int          done_cnt = 0;
  int unsigned done_cycle = 0;
  int          delay_mode = 0;   // 0 zero-wait, 1 random 0..3, 2 fixed 5, 3 never ack
  logic [31:0] g_seed;
  logic [39:0] q_words[$];
  logic [31:0] q_adr[$];

  // correlator register contents as seen by the bench
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ g_seed ^ {a[15:0], ~a[15:0]};
  endfunction

  // expected dump order: channel-major, register-minor
  function automatic logic [31:0] exp_adr(input int j);
    return 32'(BASE + 32'((j / int'(REGS)) * (1 << CH_SHIFT)) + 32'((j % int'(REGS)) * 4));
  endfunction

  function automatic logic [7:0] exp_tag(input int j);
    return 8'(((j / int'(REGS)) << 4) + (j % int'(REGS)));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_accum();
    accum = 1'b1;
    tick(1);
    accum = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic check_dumps(input int nd);
    int exp_n = nd * NWORDS;
    check("word_count", 32'(q_words.size()), 32'(exp_n));
    check("adr_count", 32'(q_adr.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < q_words.size(); i++) begin
      check("word_tag", 32'(q_words[i][39:32]), 32'(exp_tag(i % NWORDS)));
      check("word_dat", q_words[i][31:0], mem_word(exp_adr(i % NWORDS)));
    end
    for (int i = 0; i < exp_n && i < q_adr.size(); i++)
      check("req_adr", q_adr[i], exp_adr(i % NWORDS));
  endtask

  task automatic clear_q();
    q_words.delete();
    q_adr.delete();
  endtask

  // correlator bridge: acks after a per-transaction wait, driven just after the edge
  initial begin : responder
    bit in_txn;
    int wcnt;
    int dly;
    in_txn = 1'b0;
    wcnt = 0;
    dly = 0;
    bus.cor_ack_i = 1'b0;
    bus.cor_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.cor_cyc_o && bus.cor_stb_o) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          wcnt = 0;
          case (delay_mode)
            0: dly = 0;
            1: dly = int'($urandom_range(0, 3));
            2: dly = 5;
            default: dly = 100000;
          endcase
        end
        if (wcnt >= dly) begin
          bus.cor_ack_i = 1'b1;
          bus.cor_dat_i = mem_word(bus.cor_adr_o);
        end else begin
          bus.cor_ack_i = 1'b0;
          bus.cor_dat_i = $urandom;
          wcnt++;
        end
      end else begin
        in_txn = 1'b0;
        bus.cor_ack_i = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // stream monitor: collects accepted words and sequencer request addresses
  initial begin : monitor
    logic        stall_prev;
    logic        done_prev;
    logic [31:0] prev_dat;
    logic [7:0]  prev_tag;
    stall_prev = 1'b0;
    done_prev = 1'b0;
    prev_dat = '0;
    prev_tag = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", 32'(bus.dump_valid_o), 32'd1);
          check("stall_dat", bus.dump_dat_o, prev_dat);
          check("stall_tag", 32'(bus.dump_tag_o), 32'(prev_tag));
        end
        if (bus.dump_valid_o) check("no_stb_while_valid", 32'(bus.cor_stb_o), 32'd0);
        if (done) begin
          done_cnt++;
          done_cycle = cycle;
          check("done_width", 32'(done_prev), 32'd0);
        end
        done_prev = done;
        if (bus.cor_cyc_o && bus.cor_stb_o && bus.cor_ack_i && bus.cor_sel_o == 4'hF)
          q_adr.push_back(bus.cor_adr_o);
        if (bus.dump_valid_o && bus.dump_ready_i)
          q_words.push_back({bus.dump_tag_o, bus.dump_dat_o});
        stall_prev = bus.dump_valid_o && !bus.dump_ready_i;
        prev_dat = bus.dump_dat_o;
        prev_tag = bus.dump_tag_o;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          d0;
    int          k;
    int          n;
    int unsigned t0;
    logic [31:0] a;
    logic [31:0] held;
    logic        any_act;

    g_seed = $urandom;
    bus.cpu_adr_i = '0;
    bus.cpu_dat_i = '0;
    bus.cpu_sel_i = '0;
    bus.cpu_stb_i = 1'b0;
    bus.cpu_cyc_i = 1'b0;
    bus.cpu_we_i  = 1'b0;
    bus.dump_ready_i = 1'b1;

    // reset values
    tick(3);
    check("rst_cor_cyc", 32'(bus.cor_cyc_o), 32'd0);
    check("rst_cor_stb", 32'(bus.cor_stb_o), 32'd0);
    check("rst_cor_adr", bus.cor_adr_o, 32'd0);
    check("rst_valid", 32'(bus.dump_valid_o), 32'd0);
    check("rst_dat", bus.dump_dat_o, 32'd0);
    check("rst_tag", 32'(bus.dump_tag_o), 32'd0);
    check("rst_cpu_ack", 32'(bus.cpu_ack_o), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    rst = 1'b0;
    tick(3);

    // single dump, zero-wait ack, ready held high: latency and throughput
    delay_mode = 0;
    clear_q();
    d0 = done_cnt;
    pulse_accum();
    check("lat_stb_cycle1", 32'(bus.cor_stb_o), 32'd0);
    tick(1);
    check("lat_stb_cycle2", 32'(bus.cor_stb_o), 32'd1);
    t0 = cycle;
    wait_done(d0 + 1, 400, "dump1_done");
    check("dump1_cycles", done_cycle - t0, 32'(2 * NWORDS));
    tick(5);
    check("dump1_one_done", 32'(done_cnt), 32'(d0 + 1));
    check_dumps(1);

    // back-pressure on word 3, then random ready and random ack waits
    delay_mode = 1;
    clear_q();
    d0 = done_cnt;
    pulse_accum();
    k = 0;
    while (!(bus.dump_valid_o && bus.dump_tag_o == 8'h03) && k < 200) begin
      tick(1);
      k++;
    end
    check("word3_seen", 32'(bus.dump_valid_o && bus.dump_tag_o == 8'h03), 32'd1);
    bus.dump_ready_i = 1'b0;
    held = bus.dump_dat_o;
    tick(10);
    check("stall_hold_valid", 32'(bus.dump_valid_o), 32'd1);
    check("stall_hold_tag", 32'(bus.dump_tag_o), 32'h03);
    check("stall_hold_dat", bus.dump_dat_o, held);
    check("stall_accepted", 32'(q_words.size()), 32'd3);
    k = 0;
    while (done_cnt < d0 + 1 && k < 3000) begin
      bus.dump_ready_i = ($urandom_range(0, 3) != 0);
      tick(1);
      k++;
    end
    bus.dump_ready_i = 1'b1;
    wait_done(d0 + 1, 10, "dump2_done");
    check_dumps(1);

    // CPU read in flight when the interrupt rises
    delay_mode = 2;
    clear_q();
    d0 = done_cnt;
    a = 32'($urandom_range(0, 255)) << 2;
    bus.cpu_adr_i = a;
    bus.cpu_sel_i = 4'h3;
    bus.cpu_we_i  = 1'b0;
    bus.cpu_cyc_i = 1'b1;
    bus.cpu_stb_i = 1'b1;
    tick(2);
    pulse_accum();
    k = 0;
    @(negedge clk);
    while (!bus.cpu_ack_o && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("cpu1_ack", 32'(bus.cpu_ack_o), 32'd1);
    check("cpu1_dat", bus.cpu_dat_o, mem_word(a));
    check("cpu1_before_seq", 32'(q_adr.size()), 32'd0);
    @(posedge clk);
    #1;
    bus.cpu_cyc_i = 1'b0;
    bus.cpu_stb_i = 1'b0;
    wait_done(d0 + 1, 1200, "dump3_done");
    check_dumps(1);

    // CPU request raised during a dump waits for the dump to finish
    delay_mode = 0;
    tick(3);
    clear_q();
    d0 = done_cnt;
    pulse_accum();
    k = 0;
    while (q_words.size() < 10 && k < 100) begin
      tick(1);
      k++;
    end
    a = 32'($urandom_range(0, 255)) << 2;
    bus.cpu_adr_i = a;
    bus.cpu_cyc_i = 1'b1;
    bus.cpu_stb_i = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.cpu_ack_o && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("cpu2_ack", 32'(bus.cpu_ack_o), 32'd1);
    check("cpu2_after_done", 32'(done_cnt), 32'(d0 + 1));
    check("cpu2_dat", bus.cpu_dat_o, mem_word(a));
    @(posedge clk);
    #1;
    bus.cpu_cyc_i = 1'b0;
    bus.cpu_stb_i = 1'b0;
    tick(3);
    check_dumps(1);

    // two extra interrupts during a dump: two overruns, one follow-up dump
    delay_mode = 1;
    clear_q();
    d0 = done_cnt;
    check("ovr_before", 32'(ovr), 32'd0);
    pulse_accum();
    tick(20);
    pulse_accum();
    tick(30);
    pulse_accum();
    wait_done(d0 + 2, 1500, "overrun_done");
    check("ovr_count", 32'(ovr), 32'd2);
    tick(200);
    check("ovr_no_third", 32'(done_cnt), 32'(d0 + 2));
    check_dumps(2);

    // correlator never acks: abort after TIMEOUT cycles, then recover
    delay_mode = 3;
    clear_q();
    d0 = done_cnt;
    pulse_accum();
    k = 0;
    while (!bus.cor_stb_o && k < 10) begin
      tick(1);
      k++;
    end
    n = 0;
    while (bus.cor_stb_o && n < 100) begin
      n++;
      tick(1);
    end
    check("tmo_stb_cycles", 32'(n), 32'(TMO));
    check("tmo_err", 32'(err), 32'd1);
    tick(5);
    check("tmo_cyc_low", 32'(bus.cor_cyc_o), 32'd0);
    check("tmo_no_done", 32'(done_cnt), 32'(d0));
    check("tmo_no_words", 32'(q_words.size()), 32'd0);
    delay_mode = 0;
    pulse_accum();
    wait_done(d0 + 1, 400, "tmo_recover_done");
    check("tmo_err_sticky", 32'(err), 32'd1);
    check_dumps(1);

    // asynchronous reset while a word waits in the output stage
    clear_q();
    bus.dump_ready_i = 1'b0;
    pulse_accum();
    k = 0;
    while (!bus.dump_valid_o && k < 20) begin
      tick(1);
      k++;
    end
    check("pre_rst_valid", 32'(bus.dump_valid_o), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_cor_cyc", 32'(bus.cor_cyc_o), 32'd0);
    check("arst_cor_stb", 32'(bus.cor_stb_o), 32'd0);
    check("arst_valid", 32'(bus.dump_valid_o), 32'd0);
    check("arst_dat", bus.dump_dat_o, 32'd0);
    check("arst_tag", 32'(bus.dump_tag_o), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_ovr", 32'(ovr), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    tick(2);
    rst = 1'b0;
    bus.dump_ready_i = 1'b1;
    clear_q();
    d0 = done_cnt;
    any_act = 1'b0;
    repeat (20) begin
      tick(1);
      if (bus.cor_stb_o || bus.dump_valid_o) any_act = 1'b1;
    end
    check("post_rst_quiet", 32'(any_act), 32'd0);
    check("post_rst_no_done", 32'(done_cnt), 32'(d0));

    // interrupt held high through reset release counts as a rise
    accum = 1'b1;
    rst = 1'b1;
    tick(2);
    clear_q();
    rst = 1'b0;
    wait_done(d0 + 1, 400, "held_int_done");
    accum = 1'b0;
    tick(3);
    check_dumps(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
